// File: rtl/shift_register_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package shift_register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift/rotate modes are the contiguous block SHL..ASR.
    function automatic logic is_shift(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One-step next-value function, shared by single-step and burst paths.
module shift_step_unit
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_in_l_i,
    input  logic             ser_in_r_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_LOAD: q_next_o = d_i;
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], ser_in_r_i};
            MODE_SHR:  q_next_o = {ser_in_l_i, q_i[WIDTH-1:1]};
            MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_CLR:  q_next_o = '0;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit register: hold/load/clear/shift/rotate, single-step or
// counted burst with busy/done handshake.
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             done_q, done_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    n_clamp;

    // A running burst keeps using the mode latched at start.
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;
    assign n_clamp   = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;

    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .q_i        (q_q),
        .mode_i     (step_mode),
        .d_i        (d),
        .ser_in_l_i (ser_in_l),
        .ser_in_r_i (ser_in_r),
        .q_next_o   (q_next)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    done_d = 1'b1;
                    if (!is_shift(mode) || (n_clamp != '0))
                        q_d = q_next;
                    // Bursts of two or more shifts finish in RUN; shorter ones complete now.
                    if (is_shift(mode) && (n_clamp >= CW'(2))) begin
                        state_d = ST_RUN;
                        rem_d   = n_clamp - CW'(1);
                        done_d  = 1'b0;
                    end
                end else if (en) begin
                    q_d = q_next;
                end
            end
            ST_RUN: begin
                q_d = q_next;
                if (rem_q != '0)
                    rem_d = rem_q - CW'(1);
                if (rem_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            q_q     <= RESET_VAL;
            mode_q  <= MODE_HOLD;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign ser_out_l = q_q[WIDTH-1];
    assign ser_out_r = q_q[0];
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;

endmodule
